stopwatch_ctrl: RTL and testbench

Front-end controller that sequences the stopwatch time core. It conditions the raw board inputs: debounces the pause and reset buttons, and synchronizes the adjust and select switches. It generates the phase-aligned 1 Hz, 2 Hz and blink enables. It issues single-cycle core reset and pause-toggle pulses, and mirrors the core's run state for status LEDs.

---
 rtl/stopwatch_ctrl_if.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Board-side bundle of the stopwatch front-end: raw buttons/switches in,
// conditioned enables, pulses and status out.
interface stopwatch_ctrl_if;
    logic btn_pause;
    logic btn_rst;
    logic sw_adj;
    logic sw_sel;
    logic en_1hz;
    logic en_2hz;
    logic blink_on;
    logic core_rst;
    logic pause_edge;
    logic adj;
    logic sel;
    logic run_led;

    // master: the controller itself; slave: the board / time core around it
    modport master (
        input  btn_pause, btn_rst, sw_adj, sw_sel,
        output en_1hz, en_2hz, blink_on, core_rst, pause_edge, adj, sel, run_led
    );

    modport slave (
        output btn_pause, btn_rst, sw_adj, sw_sel,
        input  en_1hz, en_2hz, blink_on, core_rst, pause_edge, adj, sel, run_led
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: input synchronizers, button debouncers, phase-aligned
// 1 Hz / 2 Hz / blink enables, core reset / pause pulses and run-state mirror.
// Optional: define STOPWATCH_PAUSE_LOCK_EN to suppress pause_edge while adj=1.
`default_nettype none

module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SAMPLE_HZ   = 1000,
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    stopwatch_ctrl_if.master bus
);

    localparam int unsigned SAMP_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned HALF_DIV = CLK_HZ / 2;
    localparam int          SAMP_W   = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;
    localparam int          HALF_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int          DEB_W    = $clog2(DEB_SAMPLES + 1);

    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMP_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_SAMPLES - 1);

    // Bit positions inside the synchronizer vectors.
    localparam int IDX_PAUSE = 0;
    localparam int IDX_RST   = 1;
    localparam int IDX_ADJ   = 2;
    localparam int IDX_SEL   = 3;

    typedef enum logic {
        RUN_PAUSED = 1'b0,
        RUN_ACTIVE = 1'b1
    } run_state_t;

    logic [3:0]            raw_in;
    logic [3:0]            sync_s1;
    logic [3:0]            sync_s2;
    logic [SAMP_W-1:0]     samp_cnt;
    logic                  samp_tick;
    logic [1:0]            deb_level;
    logic [1:0]            deb_level_d;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic                  adj_d;
    logic                  rst_d;
    logic                  pause_rise;
    logic                  btn_rst_rise;
    logic                  adj_rise;
    logic                  pause_fire;
    logic                  pause_edge_q;
    logic                  core_rst_q;
    logic [HALF_W-1:0]     d2;
    logic                  ph;
    logic                  en_2hz;
    logic                  realign;
    run_state_t            run_state;
    run_state_t            run_next;

    assign raw_in = {bus.sw_sel, bus.sw_adj, bus.btn_rst, bus.btn_pause};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            // NOTE: non-blocking keeps s1 and s2 as two distinct flops; with
            // blocking assignments the chain would collapse into a single stage.
            sync_s1 <= raw_in;
            sync_s2 <= sync_s1;
        end
    end

    assign samp_tick = (samp_cnt == SAMP_LAST);

    always_ff @(posedge clk) begin
        if (rst || samp_tick) begin
            samp_cnt <= '0;
        end else begin
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

    // A level flips only after DEB_SAMPLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level <= '0;
            deb_cnt   <= '0;
        end else if (samp_tick) begin
            for (int i = 0; i < 2; i++) begin
                if (sync_s2[i] != deb_level[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_level[i] <= ~deb_level[i];
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level_d <= '0;
            adj_d       <= 1'b0;
        end else begin
            deb_level_d <= deb_level;
            adj_d       <= sync_s2[IDX_ADJ];
        end
    end

    // Remembers that rst was high at the previous edge, stretching core_rst by one cycle.
    always_ff @(posedge clk) begin
        rst_d <= rst;
    end

    assign pause_rise   = deb_level[IDX_PAUSE] & ~deb_level_d[IDX_PAUSE];
    assign btn_rst_rise = deb_level[IDX_RST] & ~deb_level_d[IDX_RST];
    assign adj_rise     = sync_s2[IDX_ADJ] & ~adj_d;

`ifdef STOPWATCH_PAUSE_LOCK_EN
    assign pause_fire = pause_rise & ~sync_s2[IDX_ADJ];
`else
    assign pause_fire = pause_rise;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_edge_q <= 1'b0;
            core_rst_q   <= 1'b1;
        end else begin
            pause_edge_q <= pause_fire;
            core_rst_q   <= rst_d | btn_rst_rise;
        end
    end

    // Entering adjust or resetting the core restarts the half-second period.
    assign en_2hz  = (d2 == HALF_LAST);
    assign realign = core_rst_q | adj_rise;

    always_ff @(posedge clk) begin
        if (rst || realign) begin
            d2 <= '0;
            ph <= 1'b0;
        end else if (en_2hz) begin
            d2 <= '0;
            ph <= ~ph;
        end else begin
            d2 <= d2 + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_state <= RUN_ACTIVE;
        end else begin
            run_state <= run_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns run_next; no latch is inferred.
        run_next = run_state;
        if (core_rst_q) begin
            run_next = RUN_ACTIVE;
        end else if (pause_edge_q) begin
            run_next = (run_state == RUN_ACTIVE) ? RUN_PAUSED : RUN_ACTIVE;
        end
    end

    assign bus.en_2hz     = en_2hz;
    assign bus.en_1hz     = en_2hz & ph;
    assign bus.blink_on   = ~ph;
    assign bus.core_rst   = core_rst_q;
    assign bus.pause_edge = pause_edge_q;
    assign bus.adj        = sync_s2[IDX_ADJ];
    assign bus.sel        = sync_s2[IDX_SEL];
    assign bus.run_led    = (run_state == RUN_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

    localparam int CLK_HZ      = 20;
    localparam int SAMPLE_HZ   = 10;
    localparam int DEB_SAMPLES = 3;
    localparam int HALF        = CLK_HZ / 2;
    localparam int SAMP_DIV    = CLK_HZ / SAMPLE_HZ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_HZ  (SAMPLE_HZ),
        .DEB_SAMPLES(DEB_SAMPLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [4:0] got;
        logic [4:0] exp;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus.core_rst, bus.en_2hz, bus.en_1hz, bus.blink_on, bus.run_led};
        exp = 5'b10011;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", got, exp);
        end
        rst = 1'b0;
        // t = 0 is the stretched core_rst cycle after rst falls
        for (int t = 0; t <= 4 * HALF + 2; t++) begin
            @(negedge clk);
            exp[4] = (t == 0);
            exp[3] = (t > 0) && (t % HALF == 0);
            exp[2] = (t > 0) && (t % (2 * HALF) == 0);
            exp[1] = (t == 0) || (((t - 1) / HALF) % 2 == 0);
            exp[0] = 1'b1;
            got = {bus.core_rst, bus.en_2hz, bus.en_1hz, bus.blink_on, bus.run_led};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_release t=%0d {core_rst,en_2hz,en_1hz,blink,run}: got %b expected %b", t, got, exp);
            end
        end
    endtask

    task automatic test_pause_debounce();
        int pe_cnt;
        int pe_first;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.pause_edge !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch_pause_edge i=%0d: got %b expected 0", i, bus.pause_edge);
            end
            bus.btn_pause = (i % 3 == 0);
        end
        for (int press = 0; press < 2; press++) begin
            pe_cnt   = 0;
            pe_first = -1;
            @(negedge clk);
            bus.btn_pause = 1'b1;
            for (int j = 1; j <= 16; j++) begin
                @(negedge clk);
                if (bus.pause_edge === 1'b1) begin
                    pe_cnt++;
                    if (pe_first < 0) pe_first = j;
                end
            end
            vectors++;
            if (pe_cnt != 1 || pe_first < 6 || pe_first > 10) begin
                miscompares++;
                $display("FAIL press%0d_pause_edge: got count %0d at %0d expected count 1 within 6..10", press, pe_cnt, pe_first);
            end
            vectors++;
            if (bus.run_led !== (press == 1)) begin
                miscompares++;
                $display("FAIL press%0d_run_led: got %b expected %b", press, bus.run_led, press == 1);
            end
            bus.btn_pause = 1'b0;
            pe_cnt = 0;
            for (int j = 1; j <= 16; j++) begin
                @(negedge clk);
                if (bus.pause_edge === 1'b1) pe_cnt++;
            end
            vectors++;
            if (pe_cnt != 0) begin
                miscompares++;
                $display("FAIL release%0d_pause_edge: got count %0d expected 0", press, pe_cnt);
            end
        end
    endtask

    task automatic test_adjust();
        repeat ($urandom_range(0, 2 * HALF - 1)) @(negedge clk);
        @(negedge clk);
        bus.sw_adj = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            if (j == 1 || j == 2 || j == 15 || j == 16) begin
                vectors++;
                if (bus.adj !== (j == 2 || j == 15)) begin
                    miscompares++;
                    $display("FAIL adj_sync j=%0d: got %b expected %b", j, bus.adj, j == 2 || j == 15);
                end
            end
            if (j >= 3 && j <= 12) begin
                vectors++;
                if ({bus.en_2hz, bus.blink_on} !== {j == 12, 1'b1}) begin
                    miscompares++;
                    $display("FAIL adj_entry j=%0d {en_2hz,blink}: got %b%b expected %b1", j, bus.en_2hz, bus.blink_on, j == 12);
                end
            end
            if (j == 13 || j == 21 || j == 22) begin
                vectors++;
                if ({bus.en_2hz, bus.en_1hz, bus.blink_on} !== {j == 22, j == 22, 1'b0}) begin
                    miscompares++;
                    $display("FAIL adj_exit_phase j=%0d {en_2hz,en_1hz,blink}: got %b%b%b expected %b%b0",
                             j, bus.en_2hz, bus.en_1hz, bus.blink_on, j == 22, j == 22);
                end
            end
            if (j == 14) bus.sw_adj = 1'b0;
        end
    endtask

    task automatic test_core_reset();
        int cr_cnt;
        int cr_at;
        @(negedge clk);
        bus.btn_pause = 1'b1;
        repeat (16) @(negedge clk);
        bus.btn_pause = 1'b0;
        repeat (16) @(negedge clk);
        vectors++;
        if (bus.run_led !== 1'b0) begin
            miscompares++;
            $display("FAIL core_rst_pre_run_led: got %b expected 0", bus.run_led);
        end
        cr_cnt = 0;
        cr_at  = -1;
        bus.btn_rst = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (bus.core_rst === 1'b1) begin
                cr_cnt++;
                if (cr_at < 0) cr_at = t;
            end
            if (cr_at >= 0 && t == cr_at + 1) begin
                vectors++;
                if (bus.run_led !== 1'b1) begin
                    miscompares++;
                    $display("FAIL core_rst_run_led: got %b expected 1", bus.run_led);
                end
            end
            if (cr_at >= 0 && t > cr_at && t <= cr_at + 2 * HALF) begin
                vectors++;
                if ({bus.en_1hz, bus.en_2hz} !== {t == cr_at + 2 * HALF, t == cr_at + HALF || t == cr_at + 2 * HALF}) begin
                    miscompares++;
                    $display("FAIL core_rst_realign dt=%0d {en_1hz,en_2hz}: got %b%b expected %b%b", t - cr_at,
                             bus.en_1hz, bus.en_2hz, t == cr_at + 2 * HALF, t == cr_at + HALF || t == cr_at + 2 * HALF);
                end
            end
            if (t == 14) bus.btn_rst = 1'b0;
        end
        vectors++;
        if (cr_cnt != 1 || cr_at < 6 || cr_at > 10) begin
            miscompares++;
            $display("FAIL core_rst_pulse: got count %0d at %0d expected count 1 within 6..10", cr_cnt, cr_at);
        end
    endtask

    task automatic test_pause_rst_collision();
        int pe_at;
        int cr_at;
        int pe_cnt;
        int cr_cnt;
        pe_at = -1; cr_at = -1; pe_cnt = 0; cr_cnt = 0;
        @(negedge clk);
        bus.btn_pause = 1'b1;
        bus.btn_rst   = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            if (bus.pause_edge === 1'b1) begin pe_cnt++; pe_at = t; end
            if (bus.core_rst === 1'b1) begin cr_cnt++; cr_at = t; end
            vectors++;
            if (bus.run_led !== 1'b1) begin
                miscompares++;
                $display("FAIL collision_run_led t=%0d: got %b expected 1", t, bus.run_led);
            end
            if (t == 16) begin
                bus.btn_pause = 1'b0;
                bus.btn_rst   = 1'b0;
            end
        end
        vectors++;
        if (pe_cnt != 1 || cr_cnt != 1 || pe_at != cr_at) begin
            miscompares++;
            $display("FAIL collision_alignment: got pause %0dx@%0d core_rst %0dx@%0d expected one each in the same cycle",
                     pe_cnt, pe_at, cr_cnt, cr_at);
        end
    endtask

    task automatic test_pause_lock();
        int pe_cnt;
        int exp_cnt;
        logic exp_led;
`ifdef STOPWATCH_PAUSE_LOCK_EN
        exp_cnt = 0;
        exp_led = 1'b1;
`else
        exp_cnt = 1;
        exp_led = 1'b0;
`endif
        pe_cnt = 0;
        @(negedge clk);
        bus.sw_adj = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_pause = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (bus.pause_edge === 1'b1) pe_cnt++;
            if (t == 16) bus.sw_adj = 1'b0;
        end
        vectors++;
        if (pe_cnt != exp_cnt || bus.run_led !== exp_led) begin
            miscompares++;
            $display("FAIL pause_lock: got %0d edges run_led %b expected %0d edges run_led %b", pe_cnt, bus.run_led, exp_cnt, exp_led);
        end
        bus.btn_pause = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    // Randomized run against a model built from the behavioural rules:
    // the divider is tracked as cycles elapsed since the last realignment.
    task automatic test_random();
        logic [3:0] m_s1, m_s2, raw;
        logic       m_level [2];
        logic       m_level_prev [2];
        int         m_diff [2];
        logic       m_adj_prev, m_rst_prev, m_core, m_pe, m_led;
        int         m_since, m_phase;
        int         left [4];
        logic       r, tick, p_rise, r_rise, a_rise, fire, smp;
        logic       n_core, n_pe, n_led;
        int         n_phase;
        logic [7:0] got, exp;
        logic       ph;
        raw = '0;
        for (int k = 0; k < 4; k++) left[k] = 1;
        m_s1 = '0; m_s2 = '0; m_adj_prev = 0; m_rst_prev = 1; m_core = 1; m_pe = 0; m_led = 1;
        m_since = 0; m_phase = 0;
        for (int k = 0; k < 2; k++) begin m_level[k] = 0; m_level_prev[k] = 0; m_diff[k] = 0; end
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (i > 0) begin
                ph  = ((m_phase / HALF) % 2) == 1;
                exp = {(m_phase % HALF == HALF - 1) && ph, (m_phase % HALF == HALF - 1), !ph,
                       m_core, m_pe, m_s2[2], m_s2[3], m_led};
                got = {bus.en_1hz, bus.en_2hz, bus.blink_on, bus.core_rst, bus.pause_edge, bus.adj, bus.sel, bus.run_led};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL random cyc=%0d {en1,en2,blink,crst,pe,adj,sel,led}: got %b expected %b", i, got, exp);
                end
            end
            r = (i < 2) || ($urandom_range(0, 599) == 0);
            for (int k = 0; k < 4; k++) begin
                left[k]--;
                if (left[k] <= 0) begin
                    raw[k] = ~raw[k];
                    case (k)
                        0:       left[k] = $urandom_range(1, 16);
                        1:       left[k] = raw[k] ? $urandom_range(1, 16) : $urandom_range(20, 200);
                        2:       left[k] = $urandom_range(5, 80);
                        default: left[k] = $urandom_range(1, 30);
                    endcase
                end
            end
            rst = r;
            {bus.sw_sel, bus.sw_adj, bus.btn_rst, bus.btn_pause} = raw;
            tick   = (m_since % SAMP_DIV) == SAMP_DIV - 1;
            p_rise = m_level[0] && !m_level_prev[0];
            r_rise = m_level[1] && !m_level_prev[1];
            a_rise = m_s2[2] && !m_adj_prev;
`ifdef STOPWATCH_PAUSE_LOCK_EN
            fire = p_rise && !m_s2[2];
`else
            fire = p_rise;
`endif
            if (r) begin
                m_s1 = '0; m_s2 = '0; m_adj_prev = 0; m_rst_prev = 1; m_core = 1; m_pe = 0; m_led = 1;
                m_since = 0; m_phase = 0;
                for (int k = 0; k < 2; k++) begin m_level[k] = 0; m_level_prev[k] = 0; m_diff[k] = 0; end
            end else begin
                n_core  = m_rst_prev || r_rise;
                n_pe    = fire;
                n_led   = m_core ? 1'b1 : (m_pe ? !m_led : m_led);
                n_phase = (m_core || a_rise) ? 0 : m_phase + 1;
                for (int k = 0; k < 2; k++) begin
                    m_level_prev[k] = m_level[k];
                    if (tick) begin
                        smp = m_s2[k];
                        m_diff[k] = (smp != m_level[k]) ? m_diff[k] + 1 : 0;
                        if (m_diff[k] == DEB_SAMPLES) begin
                            m_level[k] = !m_level[k];
                            m_diff[k]  = 0;
                        end
                    end
                end
                m_adj_prev = m_s2[2];
                m_s2 = m_s1;
                m_s1 = raw;
                m_since++;
                m_rst_prev = 0;
                m_core  = n_core;
                m_pe    = n_pe;
                m_led   = n_led;
                m_phase = n_phase;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.btn_pause = 1'b0;
        bus.btn_rst   = 1'b0;
        bus.sw_adj    = 1'b0;
        bus.sw_sel    = 1'b0;
        test_reset();
        test_pause_debounce();
        test_adjust();
        test_core_reset();
        test_pause_rst_collision();
        test_pause_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
